// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared constants and types for the instruction fetch stage.
//   DEF_PC_WIDTH  default byte-address width of the PC
//   DEF_RESET_PC  default PC loaded on reset (word aligned)
//   PC_STEP       byte increment between sequential fetches
//   INST_NOP      instruction shown to ID when nothing is buffered
//   rsp_action_e  what the fetch stage does with a memory response
//   cnt_width()   width of counters that must hold 0..depth inclusive
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int          DEF_PC_WIDTH = 10;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_DROP,
        RSP_KEEP
    } rsp_action_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Generic synchronous FIFO with a registered head entry.
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write an entry (ignored when full unless a pop frees a slot)
//   pop           remove the head entry (ignored when empty)
//   flush         empty the FIFO; the head register keeps its last value
//   count         number of stored entries (0..DEPTH)
//   full, empty   status flags
//   head          registered copy of the oldest entry; holds when empty
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RESET_HEAD = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = head_q;

    // The head register is kept equal to the oldest entry so the consumer
    // sees a flop output. It only changes when the oldest entry changes:
    // a push into an (effectively) empty FIFO, or a pop that exposes the
    // next stored entry.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
            if (do_push && (empty || (do_pop && count_q == ONE_C))) begin
                head_d = wdata;
            end else if (do_pop && count_q > ONE_C) begin
                head_d = mem_q[rd_ptr_q + AW'(1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= RESET_HEAD;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage: produces the sequential PC stream, issues word
// fetches to instruction memory, buffers the returned words and presents
// {pc, inst} to the decode stage. Honours decode back-pressure and EX
// redirects; responses in flight at a redirect are discarded.
//   clk, rst                   clock, synchronous active-high reset
//   imem_req_valid/ready/addr  fetch request handshake and byte address
//   imem_rsp_valid/data        in-order fetch responses
//   redirect_valid/pc          taken branch/jump from EX
//   id_valid/id_ready          handshake toward decode
//   pc, inst                   presented instruction and its PC
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          PC_WIDTH   = DEF_PC_WIDTH,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         inst
);

    localparam int                  CW             = cnt_width(FIFO_DEPTH);
    localparam int                  BW             = PC_WIDTH + 32;
    localparam logic [PC_WIDTH-1:0] RESET_FETCH_PC = RESET_PC[PC_WIDTH-1:0];
    localparam logic [PC_WIDTH-1:0] STEP           = PC_STEP[PC_WIDTH-1:0];
    localparam logic [CW:0]         DEPTH_C        = (CW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0]       BUF_RESET_HEAD = {{PC_WIDTH{1'b0}}, INST_NOP};

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       discard_q, discard_d;

    logic [CW-1:0]       buf_count, tag_count;
    logic                buf_full, buf_empty, tag_full, tag_empty;
    logic [BW-1:0]       buf_head;
    logic [PC_WIDTH-1:0] tag_head;
    logic [CW:0]         credits_used;
    logic                req_fire, rsp_fire, buf_push, buf_pop;
    rsp_action_e         rsp_action;

    // Every request holds a credit from issue until its instruction leaves
    // the buffer, so the buffer can never overflow.
    assign credits_used   = {1'b0, buf_count} + {1'b0, outstanding_q};
    assign imem_req_valid = !rst && !redirect_valid && (credits_used < DEPTH_C);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding (e.g. a leftover from before a
    // reset) is not ours and is ignored.
    assign rsp_fire       = imem_rsp_valid && (outstanding_q != '0);

    // Responses in a redirect cycle, or owed to a pre-redirect request,
    // belong to the abandoned path.
    always_comb begin
        rsp_action = RSP_NONE;
        if (rsp_fire) begin
            if (redirect_valid || discard_q != '0) begin
                rsp_action = RSP_DROP;
            end else begin
                rsp_action = RSP_KEEP;
            end
        end
    end

    // On a redirect everything still in flight after this cycle is stale,
    // so discard is reloaded from the updated outstanding count rather
    // than accumulated; this cannot underflow across back-to-back redirects.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        discard_d     = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~PC_WIDTH'(3);
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (rsp_fire && discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_FETCH_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign buf_push = (rsp_action == RSP_KEEP);
    assign buf_pop  = id_valid && id_ready && !redirect_valid;

    fetch_fifo #(
        .WIDTH      (BW),
        .DEPTH      (FIFO_DEPTH),
        .RESET_HEAD (BUF_RESET_HEAD)
    ) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .wdata ({tag_head, imem_rsp_data}),
        .pop   (buf_pop),
        .flush (redirect_valid),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (buf_head)
    );

    // Tags follow requests, not the fetch path, so they are never flushed:
    // stale responses still need their tag popped.
    fetch_fifo #(
        .WIDTH      (PC_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .RESET_HEAD ('0)
    ) u_pc_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .wdata (fetch_pc_q),
        .pop   (rsp_fire),
        .flush (1'b0),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty),
        .head  (tag_head)
    );

    assign id_valid = !buf_empty;
    assign pc       = buf_head[BW-1:32];
    assign inst     = buf_empty ? INST_NOP : buf_head[31:0];

    a_rsp_has_request : assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> !tag_empty);
    a_tags_track_outstanding : assert property (@(posedge clk) disable iff (rst)
        tag_count == outstanding_q);
    a_tag_queue_room : assert property (@(posedge clk) disable iff (rst)
        req_fire |-> !tag_full);
    a_buffer_room : assert property (@(posedge clk) disable iff (rst)
        (rsp_action == RSP_KEEP) |-> (!buf_full || buf_pop));

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int            PCW    = 10;
    localparam int            DEPTH  = 2;
    localparam logic [PCW-1:0] RST_PC = '0;

    logic           clk = 1'b0;
    logic           rst;
    logic           imem_req_valid;
    logic           imem_req_ready;
    logic [PCW-1:0] imem_addr;
    logic           imem_rsp_valid;
    logic [31:0]    imem_rsp_data;
    logic           redirect_valid;
    logic [PCW-1:0] redirect_pc;
    logic           id_valid;
    logic           id_ready;
    logic [PCW-1:0] pc;
    logic [31:0]    inst;

    always #5 clk = ~clk;

    inst_fetch #(
        .PC_WIDTH   (PCW),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .pc             (pc),
        .inst           (inst)
    );

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [31:0]    inst;
    } exp_t;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } rsp_t;

    // Expected decode stream: instructions in program order from the
    // latest reset/redirect target, each carrying the memory word at its PC.
    exp_t           exp_q[$];
    rsp_t           pend_q[$];
    logic [31:0]    mem_img [256];
    logic [PCW-1:0] next_pc;
    logic [PCW-1:0] exp_fetch_pc;
    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    int             last_due = 0;
    int             hs_count = 0;
    int             lat_min = 1;
    int             lat_max = 1;
    int             req_ready_pct = 100;
    bit             mon_en = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, play the memory,
    // keep the reference model in step and record any accepted request.
    task automatic applyStimulus(input bit do_rst, input bit do_redir,
                                 input logic [PCW-1:0] tgt, input bit rdy);
        exp_t e;
        rsp_t r;
        int   due;
        @(negedge clk);
        cyc++;
        rst            = do_rst;
        redirect_valid = do_redir && !do_rst;
        redirect_pc    = tgt;
        id_ready       = rdy;
        imem_req_ready = ($urandom_range(99) < req_ready_pct);
        if (do_rst) begin
            pend_q.delete();
            last_due     = cyc;
            exp_q.delete();
            next_pc      = RST_PC;
            exp_fetch_pc = RST_PC;
        end else if (do_redir) begin
            exp_q.delete();
            next_pc      = tgt & ~PCW'(3);
            exp_fetch_pc = next_pc;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (!do_rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            r              = pend_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = r.data;
        end
        while (exp_q.size() < 8) begin
            e.pc   = next_pc;
            e.inst = mem_img[next_pc[PCW-1:2]];
            exp_q.push_back(e);
            next_pc = next_pc + PCW'(4);
        end
        #1;
        if (do_rst || do_redir) begin
            checkOutput("req_valid_blocked", 64'(imem_req_valid), 64'(0));
        end else if (imem_req_valid && imem_req_ready) begin
            checkOutput("req_addr", 64'(imem_addr), 64'(exp_fetch_pc));
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            r.due  = due;
            r.data = mem_img[imem_addr[PCW-1:2]];
            pend_q.push_back(r);
            last_due     = due;
            exp_fetch_pc = exp_fetch_pc + PCW'(4);
        end
    endtask

    // Monitor: every decode handshake is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst && !redirect_valid && id_valid && id_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("sb_underflow", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("id_pc", 64'(pc), 64'(e.pc));
                    checkOutput("id_inst", 64'(inst), 64'(e.inst));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int             h0;
        logic [PCW-1:0] hp;
        logic [PCW-1:0] tgt;
        int             rv;

        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
        next_pc      = RST_PC;
        exp_fetch_pc = RST_PC;

        // Reset state
        repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("rst_id_valid", 64'(id_valid), 64'(0));
        checkOutput("rst_req_valid", 64'(imem_req_valid), 64'(0));
        checkOutput("rst_pc", 64'(pc), 64'(0));
        checkOutput("rst_inst", 64'(inst), 64'(INST_NOP));
        mon_en = 1'b1;

        // Reset release with single-cycle memory: first instruction two cycles later
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("lat_c0_id_valid", 64'(id_valid), 64'(0));
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("lat_c1_id_valid", 64'(id_valid), 64'(0));
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("lat_c2_id_valid", 64'(id_valid), 64'(1));
        checkOutput("lat_c2_pc", 64'(pc), 64'(RST_PC));
        h0 = hs_count;
        repeat (30) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("stream_rate", 64'((hs_count - h0) >= 19), 64'(1));

        // Decode stall: requests stop once two are buffered/outstanding
        repeat (5) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("stall_req_valid", 64'(imem_req_valid), 64'(0));
        checkOutput("stall_id_valid", 64'(id_valid), 64'(1));
        repeat (10) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Redirect with fetches in flight on a 3-cycle memory
        lat_min = 3;
        lat_max = 3;
        repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 10'h1F6, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("redir_addr", 64'(imem_addr), 64'(10'h1F4));
        repeat (15) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Redirect together with a decode pop on a non-empty buffer
        lat_min = 1;
        lat_max = 1;
        repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("flush_pre_id_valid", 64'(id_valid), 64'(1));
        hp = exp_q[0].pc;
        applyStimulus(1'b0, 1'b1, 10'h100, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("flush_id_valid", 64'(id_valid), 64'(0));
        checkOutput("flush_inst", 64'(inst), 64'(INST_NOP));
        checkOutput("flush_pc_hold", 64'(pc), 64'(hp));
        repeat (10) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 10'h3F8, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Reset with requests in flight
        lat_min = 3;
        lat_max = 3;
        repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("rst_mid_id_valid", 64'(id_valid), 64'(0));
        checkOutput("rst_mid_pc", 64'(pc), 64'(0));
        checkOutput("rst_mid_inst", 64'(inst), 64'(INST_NOP));
        repeat (12) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Randomised traffic
        lat_min       = 1;
        lat_max       = 4;
        req_ready_pct = 75;
        for (int i = 0; i < 800; i++) begin
            rv  = int'($urandom_range(199));
            tgt = PCW'($urandom);
            applyStimulus(rv == 0, (rv > 0) && (rv < 9), tgt, $urandom_range(99) < 70);
        end

        // Drain with no back-pressure
        req_ready_pct = 100;
        h0 = hs_count;
        repeat (40) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("drain_progress", 64'((hs_count - h0) > 10), 64'(1));

        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
